// File: rtl/clause_store.sv
// clause_store: clause slots with valid bits, two forwarded registered read ports
// and a sweeping engine that rewrites the value field of terms matching an assigned variable.
module clause_store #(
    parameter int NUM_CLAUSES      = 16,
    parameter int TERMS_PER_CLAUSE = 3,
    parameter int VAR_ID_WIDTH     = 8,
    parameter int TERM_WIDTH       = VAR_ID_WIDTH + 3,
    parameter int CLAUSE_WIDTH     = TERMS_PER_CLAUSE * TERM_WIDTH,
    parameter int AW               = $clog2(NUM_CLAUSES),
    parameter int HW               = $clog2(NUM_CLAUSES * TERMS_PER_CLAUSE + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [CLAUSE_WIDTH-1:0] wr_data,
    input  logic                    wr_valid,
    input  logic                    clr,
    input  logic [AW-1:0]           rd_addr_a,
    output logic [CLAUSE_WIDTH-1:0] rd_data_a,
    output logic                    rd_vld_a,
    input  logic [AW-1:0]           rd_addr_b,
    output logic [CLAUSE_WIDTH-1:0] rd_data_b,
    output logic                    rd_vld_b,
    input  logic                    asg_start,
    input  logic [VAR_ID_WIDTH-1:0] asg_var,
    input  logic [1:0]              asg_value,
    output logic                    asg_busy,
    output logic                    asg_done,
    output logic [HW-1:0]           asg_hits,
    output logic [AW:0]             num_valid
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    logic [CLAUSE_WIDTH-1:0] r_mem [NUM_CLAUSES];
    logic [NUM_CLAUSES-1:0]  r_vld;
    state_t                  r_state;
    logic [AW-1:0]           r_idx;
    logic [VAR_ID_WIDTH-1:0] r_var;
    logic [1:0]              r_val;
    logic [HW-1:0]           r_cnt;
    logic [HW-1:0]           r_hits;
    logic [CLAUSE_WIDTH-1:0] r_rd_data_a;
    logic [CLAUSE_WIDTH-1:0] r_rd_data_b;
    logic                    r_rd_vld_a;
    logic                    r_rd_vld_b;

    logic [CLAUSE_WIDTH-1:0] w_cur;
    logic [CLAUSE_WIDTH-1:0] w_bc_data;
    logic [HW-1:0]           w_bc_cnt;
    logic [HW-1:0]           w_cnt_nxt;
    logic                    w_bc_we;
    logic                    w_hw_a;
    logic                    w_hw_b;
    logic [AW:0]             w_pop;

    // Rewritten image of the slot under the sweep pointer and its match count
    always_comb begin
        w_cur     = r_mem[r_idx];
        w_bc_data = w_cur;
        w_bc_cnt  = '0;
        for (int t = 0; t < TERMS_PER_CLAUSE; t++) begin
            if (w_cur[CLAUSE_WIDTH-1-t*TERM_WIDTH -: VAR_ID_WIDTH] == r_var) begin
                w_bc_data[CLAUSE_WIDTH-1-t*TERM_WIDTH-VAR_ID_WIDTH -: 2] = r_val;
                w_bc_cnt = w_bc_cnt + HW'(1);
            end
        end
    end

    // A host write to the swept slot wins and suppresses that slot's hits
    assign w_bc_we   = rst_n && r_state == SCAN && r_vld[r_idx] && !(wr_en && wr_addr == r_idx);
    assign w_cnt_nxt = r_cnt + (w_bc_we ? w_bc_cnt : '0);
    assign w_hw_a    = wr_en && wr_addr == rd_addr_a;
    assign w_hw_b    = wr_en && wr_addr == rd_addr_b;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CLAUSES; i++) w_pop = w_pop + (AW+1)'(r_vld[i]);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_bc_we) r_mem[r_idx] <= w_bc_data;
            if (wr_en) r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld       <= '0;
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
            r_rd_vld_a  <= 1'b0;
            r_rd_vld_b  <= 1'b0;
        end else begin
            if (clr) r_vld <= '0;
            if (wr_en) r_vld[wr_addr] <= wr_valid;
            r_rd_data_a <= w_hw_a ? wr_data : (w_bc_we && r_idx == rd_addr_a) ? w_bc_data : r_mem[rd_addr_a];
            r_rd_data_b <= w_hw_b ? wr_data : (w_bc_we && r_idx == rd_addr_b) ? w_bc_data : r_mem[rd_addr_b];
            r_rd_vld_a  <= w_hw_a ? wr_valid : !clr && r_vld[rd_addr_a];
            r_rd_vld_b  <= w_hw_b ? wr_valid : !clr && r_vld[rd_addr_b];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_var   <= '0;
            r_val   <= '0;
            r_cnt   <= '0;
            r_hits  <= '0;
        end else begin
            case (r_state)
                IDLE: if (asg_start && asg_value != 2'b11) begin
                    r_state <= SCAN;
                    r_var   <= asg_var;
                    r_val   <= asg_value;
                    r_idx   <= '0;
                    r_cnt   <= '0;
                    r_hits  <= '0;
                end
                SCAN: begin
                    r_cnt <= w_cnt_nxt;
                    r_idx <= r_idx + AW'(1);
                    if (r_idx == AW'(NUM_CLAUSES - 1)) begin
                        r_state <= DONE;
                        r_hits  <= w_cnt_nxt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_data_a = r_rd_data_a;
    assign rd_data_b = r_rd_data_b;
    assign rd_vld_a  = r_rd_vld_a;
    assign rd_vld_b  = r_rd_vld_b;
    assign asg_busy  = r_state == SCAN;
    assign asg_done  = r_state == DONE;
    assign asg_hits  = r_hits;
    assign num_valid = w_pop;
endmodule

// File: doc/clause_store.md
Name: clause_store

Overview:
- Parametrised clause storage for one SAT solver node. Holds up to NUM_CLAUSES clauses of TERMS_PER_CLAUSE terms each.
- Per-clause valid bits, two independent registered read ports and a host write port with read forwarding.
- Built-in assignment-broadcast engine: sweeps every valid clause and rewrites the value field of each term whose var_id matches a newly assigned variable.
- Sits between the node controller (host) and the clause evaluation logic.

Parameters:
- NUM_CLAUSES, 16, clause slots (power of 2, >=2)
- TERMS_PER_CLAUSE, 3, terms per clause (>=1)
- VAR_ID_WIDTH, 8, variable identifier width
- TERM_WIDTH, VAR_ID_WIDTH+3, one term = {var_id, value[1:0], neg}
- CLAUSE_WIDTH, TERMS_PER_CLAUSE*TERM_WIDTH, term 0 in MSBs
- AW, $clog2(NUM_CLAUSES), address width
- HW, $clog2(NUM_CLAUSES*TERMS_PER_CLAUSE+1), hit counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- wr_en  in  1  host clause write
- wr_addr  in  AW  write slot
- wr_data  in  CLAUSE_WIDTH  clause data
- wr_valid  in  1  valid bit stored with the write (0 = invalidate slot)
- clr  in  1  invalidate all slots
- rd_addr_a  in  AW  port A address
- rd_data_a  out  CLAUSE_WIDTH  port A data
- rd_vld_a  out  1  port A slot valid
- rd_addr_b  in  AW  port B address
- rd_data_b  out  CLAUSE_WIDTH  port B data
- rd_vld_b  out  1  port B slot valid
- asg_start  in  1  start broadcast
- asg_var  in  VAR_ID_WIDTH  assigned variable
- asg_value  in  2  value to write (00 = F, 01 = T, 10 = U, 11 = reserved)
- asg_busy  out  1  broadcast in progress
- asg_done  out  1  one-cycle completion pulse
- asg_hits  out  HW  terms rewritten by the last broadcast
- num_valid  out  AW+1  popcount of the valid bitmap

Behaviour:

Reset:
- rd_data_a/b = 0, rd_vld_a/b = 0, valid bitmap = 0, num_valid = 0.
- asg_busy = 0, asg_done = 0, asg_hits = 0, FSM = IDLE.
- Clause array contents are not reset; they are meaningless until written.

Write:
- wr_en at edge t stores wr_data and wr_valid to slot wr_addr, visible from t+1.

Clear:
- clr clears every valid bit at the edge.
- clr together with wr_en: clear applies first, then the write, so the written slot takes wr_valid.

Reads:
- Both ports are registered with 1-cycle latency and are always enabled.
- Forwarding priority for the addressed slot: host write in the same cycle, then broadcast write in the same cycle, then the array.
- rd_vld_x follows the same priority, with clr applied before the host write.

num_valid:
- Combinational popcount of the registered bitmap, so it changes the cycle after a write or clr.

Broadcast FSM (IDLE, SCAN, DONE):
- IDLE: asg_start with asg_value != 11 latches asg_var/asg_value, clears the hit count, sets idx = 0, and moves to SCAN.
  - asg_start with asg_value == 11 is ignored.
  - asg_start while busy is ignored.
- SCAN: one slot per cycle, read-modify-write of slot idx.
  - If the slot is valid, every term with var_id == latched var gets its value field replaced. The neg bit and var_id are untouched.
  - hits += number of matching terms, counted even when the value is unchanged.
  - Invalid slots are skipped and their hits are not counted.
  - If the host writes slot idx in the same cycle, the host data wins and that slot contributes 0 hits.
  - When idx == NUM_CLAUSES-1, move to DONE.
- DONE: asg_done = 1 for exactly one cycle, asg_hits updated, return to IDLE.
- Timing: asg_busy is high during SCAN only. asg_start accepted at edge t gives busy for cycles t+1 .. t+NUM_CLAUSES and done at cycle t+NUM_CLAUSES+1.
- asg_hits holds its value until the next accepted start.
- clr during SCAN clears the valid bits; later slots are then skipped.
- Reset mid-SCAN returns to IDLE with no done pulse and hits = 0.

Test Plan:
1. Reset, write slot 0 = {(0,U,0),(1,U,1),(2,U,0)} valid, read A=0, B=0 next cycle -> both return the data with vld=1; num_valid=1; slot 5 reads vld=0.
2. Same-cycle write slot 3 and rd_addr_a=3 -> rd_data_a equals the new wr_data one cycle later (forwarding).
3. Load the 4-clause set (A∨¬B∨C)(¬A∨B∨¬D)(B∨C∨D)(¬A∨¬C∨D), asg_start var=0 value=01 -> busy 16 cycles, done pulse at t+17, hits=3; slots 0,1,3 show var 0 value=01 with neg bits preserved; slot 2 unchanged.
4. Start with asg_value=11, or start while busy -> ignored: no busy change, hits unchanged.
5. During a broadcast on var 3, host writes slot idx in the same cycle -> host data stored, that slot contributes 0 hits; clr mid-scan -> remaining slots skipped, num_valid=0 after the clear.
6. rst_n low mid-SCAN -> next cycle busy=0, done never pulses, hits=0, all vld=0, num_valid=0.
